// File: rtl/seg_display_arbiter_pkg.sv
// seg_display_arbiter_pkg: shared state encodings and widths for the 7-segment display arbiter.
`default_nettype none

package seg_display_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  localparam int          OWNER_W            = 3;
  localparam logic [15:0] DEFAULT_IDLE_VALUE = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/seg_display_arbiter_rr_pick.sv
// seg_display_arbiter_rr_pick: combinational round-robin search, first eligible request at or after ptr.
`default_nettype none

module seg_display_arbiter_rr_pick
  import seg_display_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  input  logic [NREQ-1:0]    mask,
  output logic               found,
  output logic [OWNER_W-1:0] winner
);

  logic [NREQ-1:0] elig;
  int              best_d;
  int              d;

  assign elig = req & ~mask;

  // Distance from ptr (modulo NREQ) orders the candidates; smallest distance wins.
  always_comb begin
    found  = |elig;
    winner = '0;
    best_d = NREQ;
    d      = 0;
    for (int j = 0; j < NREQ; j++) begin
      d = (j - int'(ptr) + NREQ) % NREQ;
      if (elig[j] && (d < best_d)) begin
        best_d = d;
        winner = OWNER_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the shared 7-segment display with minimum dwell per grant.
// Optional SEG_ARB_LOCK_EN adds a lock input that suppresses dwell-expiry pre-emption.
`default_nettype none

module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int                NREQ        = 4,
  parameter int                HOLD_W      = 24,
  parameter logic [HOLD_W-1:0] HOLD_CYCLES = 24'd12_000_000,
  parameter logic [15:0]       IDLE_VALUE  = DEFAULT_IDLE_VALUE
) (
  input  logic                 CLK,
  input  logic                 RST,
`ifdef SEG_ARB_LOCK_EN
  input  logic [NREQ-1:0]      lock,
`endif
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_value,
  output logic [NREQ-1:0]      grant,
  output logic [OWNER_W-1:0]   owner,
  output logic                 busy,
  output logic [15:0]          value
);

  // A dwell of zero behaves like a dwell of one.
  localparam logic [HOLD_W-1:0] RELOAD = (HOLD_CYCLES == '0) ? '0 : HOLD_CYCLES - 1'b1;

  state_t              state, state_n;
  logic [OWNER_W-1:0]  ptr, ptr_n;
  logic [HOLD_W-1:0]   counter, counter_n;
  logic [NREQ-1:0]     grant_n;
  logic [OWNER_W-1:0]  owner_n;
  logic                busy_n;
  logic [15:0]         value_n;

  logic [NREQ-1:0]     mask;
  logic                found;
  logic [OWNER_W-1:0]  winner;
  logic [OWNER_W-1:0]  ptr_next;
  logic [NREQ-1:0]     winner_onehot;
  logic [15:0]         owner_value;
  logic [15:0]         winner_value;
  logic                owner_req;
  logic                locked;
  logic                take;

  assign mask      = (state == ST_OWNED) ? grant : '0;
  assign owner_req = |(req & grant);
`ifdef SEG_ARB_LOCK_EN
  assign locked    = |(req & lock & grant);
`else
  assign locked    = 1'b0;
`endif

  seg_display_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .mask   (mask),
    .found  (found),
    .winner (winner)
  );

  assign ptr_next = (winner == OWNER_W'(NREQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    winner_onehot = '0;
    owner_value   = IDLE_VALUE;
    winner_value  = IDLE_VALUE;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == OWNER_W'(i)) begin
        winner_onehot[i] = 1'b1;
        winner_value     = req_value[16*i +: 16];
      end
      if (owner == OWNER_W'(i)) begin
        owner_value = req_value[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    counter_n = counter;
    grant_n   = grant;
    owner_n   = owner;
    busy_n    = busy;
    value_n   = IDLE_VALUE;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        take = found;
      end
      ST_OWNED: begin
        value_n = owner_value;
        if (!owner_req) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_n = ST_IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
            value_n = IDLE_VALUE;
          end
        end else if ((counter == '0) && !locked) begin
          // Sole requester keeps the grant untouched; only the dwell restarts.
          if (found) take = 1'b1;
          else       counter_n = RELOAD;
        end else if (counter != '0) begin
          counter_n = counter - 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (take) begin
      state_n   = ST_OWNED;
      grant_n   = winner_onehot;
      owner_n   = winner;
      busy_n    = 1'b1;
      counter_n = RELOAD;
      ptr_n     = ptr_next;
      value_n   = winner_value;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      counter <= '0;
      grant   <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      value   <= IDLE_VALUE;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      counter <= counter_n;
      grant   <= grant_n;
      owner   <= owner_n;
      busy    <= busy_n;
      value   <= value_n;
    end
  end

endmodule

`default_nettype wire
